// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory handshake, redirect inputs and the
// decode-facing instruction register handshake.
interface instr_fetch_if;
  logic        PCSrc;
  logic [31:0] PCTarget;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pcplus4;
  logic        instr_ready;

  modport master (
    input  PCSrc, PCTarget, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
    output imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pcplus4
  );

  modport slave (
    output PCSrc, PCTarget, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pcplus4
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps at most one imem request in flight
// and presents the fetched word to decode through a valid/ready register.
//
// state   | meaning
// IDLE    | first cycle out of reset, no request yet
// FETCH   | imem_req high, waiting for gnt
// WAIT    | request accepted, waiting for rvalid
// HOLD    | instruction valid, waiting for decode to take it
// DISCARD | redirected while a request was in flight; drop its response
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic           clk,
  input logic           rst_n,
  instr_fetch_if.master bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_HOLD    = 3'd3;
  localparam logic [2:0] S_DISCARD = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        imem_req_q, imem_req_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic [31:0] instr_pcplus4_q, instr_pcplus4_d;
  logic [31:0] target;

  assign target = {bus.PCTarget[31:2], 2'b00};

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    instr_valid_d   = instr_valid_q;
    instr_d         = instr_q;
    instr_pc_d      = instr_pc_q;
    instr_pcplus4_d = instr_pcplus4_q;

    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (bus.imem_gnt) state_d = S_WAIT;
      S_WAIT: begin
        if (bus.imem_rvalid) begin
          instr_d         = bus.imem_rdata;
          instr_pc_d      = pc_q;
          instr_pcplus4_d = pc_q + 32'd4;
          instr_valid_d   = 1'b1;
          pc_d            = pc_q + 32'd4;
          state_d         = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.instr_ready) begin
          instr_valid_d = 1'b0;
          instr_d       = NOP_INSTR;
          state_d       = S_FETCH;
        end
      end
      S_DISCARD: if (bus.imem_rvalid) state_d = S_FETCH;
      default:   state_d = S_IDLE;
    endcase

    // A redirect wins over everything; an accepted-but-unanswered request must be drained.
    if (bus.PCSrc) begin
      pc_d            = target;
      instr_valid_d   = 1'b0;
      instr_d         = NOP_INSTR;
      instr_pc_d      = instr_pc_q;
      instr_pcplus4_d = instr_pcplus4_q;
      case (state_q)
        S_FETCH:   state_d = bus.imem_gnt    ? S_DISCARD : S_FETCH;
        S_WAIT:    state_d = bus.imem_rvalid ? S_FETCH   : S_DISCARD;
        S_DISCARD: state_d = bus.imem_rvalid ? S_FETCH   : S_DISCARD;
        default:   state_d = S_FETCH;
      endcase
    end

    imem_req_d = (state_d == S_FETCH);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      pc_q            <= RESET_PC;
      imem_req_q      <= 1'b0;
      instr_valid_q   <= 1'b0;
      instr_q         <= NOP_INSTR;
      instr_pc_q      <= RESET_PC;
      instr_pcplus4_q <= RESET_PC + 32'd4;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      imem_req_q      <= imem_req_d;
      instr_valid_q   <= instr_valid_d;
      instr_q         <= instr_d;
      instr_pc_q      <= instr_pc_d;
      instr_pcplus4_q <= instr_pcplus4_d;
    end
  end

  assign bus.imem_req      = imem_req_q;
  assign bus.imem_addr     = pc_q;
  assign bus.instr_valid   = instr_valid_q;
  assign bus.instr         = instr_q;
  assign bus.instr_pc      = instr_pc_q;
  assign bus.instr_pcplus4 = instr_pcplus4_q;

endmodule
